clk_div_ctrl: RTL
=================

# clk_div_ctrl

Runtime-programmable clock-enable generator and configuration sequencer for the lab clock-divider datapath. It owns a period counter, accepts divide-ratio/high-time requests over a valid/ready handshake, validates them, and swaps them in only at a period boundary, so the output waveform never has a truncated or glitched period. Reset defaults reproduce the existing fixed divide-by-3, 33 % duty output; downstream logic uses it as a gated clock or enable.

## Interface
- CNT_W, 8, width of the period counter and config fields; maximum period is 2^CNT_W − 1 cycles.
- clk_in  input  1  sole clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  level; 1 = run the divider, 0 = stop at the end of the current period.
- cfg_valid  input  1  config request present.
- cfg_div  input  CNT_W  requested period in clk_in cycles.
- cfg_high  input  CNT_W  requested high cycles per period.
- cfg_ready  output  1  block can accept a config this cycle.
- cfg_err  output  1  one-cycle pulse: the request just handshaken was rejected.
- clk_out  output  1  divided output, driven directly from a flop.
- period_start  output  1  one-cycle pulse coincident with the first cycle of each output period.
- running  output  1  1 while state is RUN or STOP_PEND.

## Operation
- Active config registers div_r and high_r. Shadow registers div_s and high_s, plus a pend flag.
- Reset (rst=0, asynchronous): state IDLE, cnt=0, div_r=3, high_r=1, pend=0, clk_out=0, period_start=0, cfg_err=0, cfg_ready=1, running=0.
- Validity rule: 2 ≤ cfg_div and 1 ≤ cfg_high < cfg_div. Comparisons are unsigned at CNT_W bits.
- Handshake: accept when cfg_valid && cfg_ready. cfg_ready = !pend. Requests are never dropped silently.
- Invalid accepted request: cfg_err=1 the next cycle; active and shadow configs are unchanged; pend is unchanged.
- Valid request in IDLE: written directly to div_r/high_r the next cycle; pend stays 0.
- Valid request in RUN or STOP_PEND: written to the shadow registers; pend=1, so cfg_ready=0.
- States:
  - IDLE: cnt=0, clk_out=0. If enable=1, go to RUN.
  - RUN: cnt counts 0..div_r−1 and wraps. If enable=0, go to STOP_PEND.
  - STOP_PEND: keep counting. At cnt=div_r−1 go to IDLE. If enable returns to 1 before then, go back to RUN with no effect on the waveform.
- clk_out = 1 while running and cnt < high_r; otherwise 0.
- period_start = 1 while running and cnt = 0.
- Boundary (the cycle in which cnt = div_r−1): if pend=1, the shadow config loads into div_r/high_r, pend clears, and the next period uses the new values.
- A request accepted in the boundary cycle itself lands in the shadow registers. It applies at the following boundary, never the current one.
- Stopping applies any pending shadow config at the final boundary. The block then idles with the new config.
- Reset mid-period or while pend=1 discards the shadow contents and restores the defaults.

## Timing
- enable sampled 1 in IDLE at edge N: the first output period starts at edge N+1, with clk_out=1 and period_start=1 from that edge.
- Steady state: clk_out is high for exactly high_r cycles and low for div_r−high_r cycles. period_start pulses every div_r cycles.
- Config latency:
  - In IDLE, 1 cycle to become active.
  - While running, active from the first period that begins after the current period ends.
  - cfg_ready returns to 1 on the same edge the shadow loads.
- Stop latency: after enable falls, clk_out and running go to 0 on the edge following the last cycle of the current period.
- cfg_err asserts 1 cycle after the rejecting handshake and lasts 1 cycle.
- clk_out and period_start have no combinational path from inputs.

## Test plan
- **Reset default:** hold rst=0 for 15 ns, release, enable=1.
  - clk_out pattern 1,0,0 repeating; period_start every 3rd cycle.
  - Assert rst=0 mid-period: clk_out=0 immediately, asynchronously.
- **Idle reconfiguration:** in IDLE, send div=5, high=2, then enable=1.
  - clk_out pattern 1,1,0,0,0; cfg_ready stays 1.
- **Running reconfiguration:** while running div=3/high=1, send div=4, high=3 at cnt=1.
  - cfg_ready=0 until the boundary.
  - The current period ends 1,0,0; subsequent periods are 1,1,1,0.
- **Boundary collision:** send div=6, high=3 in the boundary cycle itself.
  - One more old-config period runs; the new config starts after it.
- **Invalid requests:** send div=1/high=1, then div=4/high=4, then div=4/high=0.
  - Each gives a one-cycle cfg_err pulse; the waveform is unchanged; pend=0.
- **Stop with pending config:** drop enable with div=8/high=4 pending.
  - The current period completes; running=0; clk_out=0.
  - Re-enabling produces 4 high cycles, then 4 low cycles.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable generator with boundary-synchronised reconfiguration.
// Config requests are validated, then applied in IDLE or at the next period boundary.
module clk_div_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             period_start,
    output logic             running
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP_PEND
    } state_t;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(3);
    localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] div_s_q, div_s_d;
    logic [CNT_W-1:0] high_s_q, high_s_d;
    logic             pend_q, pend_d;
    logic             en_q;
    logic             err_q, err_d;
    logic             clk_q, clk_d;
    logic             ps_q, ps_d;
    logic             run_q, run_d;

    logic             acc;
    logic             cfg_ok;
    logic             last;

    assign acc    = cfg_valid && !pend_q;
    assign cfg_ok = (cfg_div >= TWO) && (cfg_high >= ONE) && (cfg_high < cfg_div);
    assign last   = (state_q != IDLE) && (cnt_q == div_q - ONE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        high_d   = high_q;
        div_s_d  = div_s_q;
        high_s_d = high_s_q;
        pend_d   = pend_q;
        err_d    = 1'b0;

        if (last && pend_q) begin
            div_d  = div_s_q;
            high_d = high_s_q;
            pend_d = 1'b0;
        end

        // acc implies pend_q=0, so it never collides with the shadow load
        if (acc) begin
            if (!cfg_ok) begin
                err_d = 1'b1;
            end else if (state_q == IDLE) begin
                div_d  = cfg_div;
                high_d = cfg_high;
            end else begin
                div_s_d  = cfg_div;
                high_s_d = cfg_high;
                pend_d   = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en_q) state_d = RUN;
            end
            RUN, STOP_PEND: begin
                if (last) begin
                    cnt_d   = '0;
                    state_d = en_q ? RUN : IDLE;
                end else begin
                    cnt_d   = cnt_q + ONE;
                    state_d = en_q ? RUN : STOP_PEND;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        run_d = (state_d != IDLE);
        clk_d = run_d && (cnt_d < high_d);
        ps_d  = run_d && (cnt_d == '0);
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= DIV_RST;
            high_q   <= HIGH_RST;
            div_s_q  <= '0;
            high_s_q <= '0;
            pend_q   <= 1'b0;
            en_q     <= 1'b0;
            err_q    <= 1'b0;
            clk_q    <= 1'b0;
            ps_q     <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            high_q   <= high_d;
            div_s_q  <= div_s_d;
            high_s_q <= high_s_d;
            pend_q   <= pend_d;
            en_q     <= enable;
            err_q    <= err_d;
            clk_q    <= clk_d;
            ps_q     <= ps_d;
            run_q    <= run_d;
        end
    end

    assign cfg_ready    = !pend_q;
    assign cfg_err      = err_q;
    assign clk_out      = clk_q;
    assign period_start = ps_q;
    assign running      = run_q;

endmodule
